// File: rtl/dma_desc_scheduler.sv
// Descriptor-queue controller: CPU-staged src/dst/len triplets are queued in a FIFO
// and issued one at a time to the DMA engine over a level enable/done handshake.
module dma_desc_scheduler #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_wen,
  input  logic [2:0]  cfg_waddr,
  input  logic [31:0] cfg_wdata,
  input  logic [2:0]  cfg_raddr,
  output logic [31:0] cfg_rdata,
  output logic        dma_en,
  output logic [31:0] dma_src,
  output logic [31:0] dma_dst,
  output logic [31:0] dma_len,
  input  logic        dma_done,
  output logic        irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [31:0]   src_stage_r, dst_stage_r, len_stage_r;
  logic          run_en_r, irq_en_r, ovf_r, err_r;
  logic [31:0]   done_cnt_r;
  logic [31:0]   fifo_src_r [DEPTH];
  logic [31:0]   fifo_dst_r [DEPTH];
  logic [31:0]   fifo_len_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;

  logic          push_req_s, clr_wr_s, full_s, empty_s, pop_s, len_zero_s;
  logic          push_ok_s, ovf_set_s, err_set_s, finish_s, busy_s;
  logic [7:0]    count8_s;
  logic [31:0]   status_s;

  assign push_req_s = cfg_wen && (cfg_waddr == 3'd3);
  assign clr_wr_s   = cfg_wen && (cfg_waddr == 3'd4);
  assign full_s     = (count_r == FULL_CNT);
  assign empty_s    = (count_r == {CW{1'b0}});
  assign pop_s      = (state_r == ST_LOAD);
  assign len_zero_s = (len_stage_r == 32'd0);
  // A full FIFO still accepts a push on the LOAD cycle since the head leaves that edge.
  assign push_ok_s  = push_req_s && !len_zero_s && (!full_s || pop_s);
  assign ovf_set_s  = push_req_s && !len_zero_s && full_s && !pop_s;
  assign err_set_s  = push_req_s && len_zero_s;
  assign finish_s   = (state_r == ST_RUN) && dma_done;
  assign busy_s     = (state_r != ST_IDLE);
  assign count8_s   = 8'(count_r);
  assign status_s   = {16'd0, count8_s, 3'd0, err_r, ovf_r, busy_s, full_s, empty_s};

  // Staging and control register writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_stage_r <= 32'd0;
      dst_stage_r <= 32'd0;
      len_stage_r <= 32'd0;
      run_en_r    <= 1'b0;
      irq_en_r    <= 1'b0;
    end else if (cfg_wen) begin
      case (cfg_waddr)
        3'd0: src_stage_r <= cfg_wdata;
        3'd1: dst_stage_r <= cfg_wdata;
        3'd2: len_stage_r <= cfg_wdata;
        3'd5: begin
          run_en_r <= cfg_wdata[0];
          irq_en_r <= cfg_wdata[1];
        end
        default: ;
      endcase
    end
  end

  // Descriptor FIFO storage and write pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_src_r[i] <= 32'd0;
        fifo_dst_r[i] <= 32'd0;
        fifo_len_r[i] <= 32'd0;
      end
      wr_ptr_r <= {AW{1'b0}};
    end else if (push_ok_s) begin
      fifo_src_r[wr_ptr_r] <= src_stage_r;
      fifo_dst_r[wr_ptr_r] <= dst_stage_r;
      fifo_len_r[wr_ptr_r] <= len_stage_r;
      wr_ptr_r             <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
    end
  end

  // Read pointer and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Issue FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Issue FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (run_en_r && !empty_s) state_s = ST_LOAD;
        else                      state_s = ST_IDLE;
      end
      ST_LOAD: state_s = ST_RUN;
      ST_RUN: begin
        if (dma_done) state_s = ST_DRAIN;
        else          state_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (!dma_done) state_s = ST_GAP;
        else           state_s = ST_DRAIN;
      end
      ST_GAP:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Engine-facing outputs: loaded from the FIFO head on LOAD, held until completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dma_en  <= 1'b0;
      dma_src <= 32'd0;
      dma_dst <= 32'd0;
      dma_len <= 32'd0;
    end else if (pop_s) begin
      dma_en  <= 1'b1;
      dma_src <= fifo_src_r[rd_ptr_r];
      dma_dst <= fifo_dst_r[rd_ptr_r];
      dma_len <= fifo_len_r[rd_ptr_r];
    end else if (finish_s) begin
      dma_en  <= 1'b0;
    end
  end

  // Completion counter and sticky flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_cnt_r <= 32'd0;
      irq        <= 1'b0;
      ovf_r      <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      if (finish_s) done_cnt_r <= done_cnt_r + 32'd1;

      if (finish_s && irq_en_r)          irq <= 1'b1;
      else if (clr_wr_s && cfg_wdata[0]) irq <= 1'b0;

      if (ovf_set_s)                     ovf_r <= 1'b1;
      else if (clr_wr_s && cfg_wdata[1]) ovf_r <= 1'b0;

      if (err_set_s)                     err_r <= 1'b1;
      else if (clr_wr_s && cfg_wdata[2]) err_r <= 1'b0;
    end
  end

  // Register read mux.
  always_comb begin
    cfg_rdata = 32'd0;
    case (cfg_raddr)
      3'd0:    cfg_rdata = src_stage_r;
      3'd1:    cfg_rdata = dst_stage_r;
      3'd2:    cfg_rdata = len_stage_r;
      3'd5:    cfg_rdata = {30'd0, irq_en_r, run_en_r};
      3'd6:    cfg_rdata = status_s;
      3'd7:    cfg_rdata = done_cnt_r;
      default: cfg_rdata = 32'd0;
    endcase
  end

endmodule

// File: doc/dma_desc_scheduler.md
# dma_desc_scheduler

Descriptor-queue controller that sits between the CPU register slave and the DMA engine. The CPU stages source/destination/length triplets and pushes them into a FIFO. The block then issues them to the engine one at a time over the level-based enable/done handshake. It counts completions and raises a single level interrupt, so software no longer babysits each transfer.

## Interface
- DEPTH, 4: descriptor FIFO depth; power of two, 2..16.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cfg_wen  in  1  register write strobe, one write per asserted cycle.
- cfg_waddr  in  3  write register index.
- cfg_wdata  in  32  write data.
- cfg_raddr  in  3  read register index.
- cfg_rdata  out  32  combinational read data.
- dma_en  out  1  engine enable (level); registered.
- dma_src  out  32  engine source address; registered, stable while dma_en=1.
- dma_dst  out  32  engine destination address; registered, stable while dma_en=1.
- dma_len  out  32  engine length; registered, stable while dma_en=1.
- dma_done  in  1  engine completion (level), high from finish until engine sees dma_en=0.
- irq  out  1  completion interrupt (level); registered.

## Operation
- Write map:
  - 0 SRC_STAGE; 1 DST_STAGE; 2 LEN_STAGE.
  - 3 PUSH: any data pushes the staged triplet.
  - 4 CLR: bit0 clears irq, bit1 clears ovf, bit2 clears err.
  - 5 CTRL: bit0 run_en, bit1 irq_en.
  - 6 and 7: writes ignored.
- Read map:
  - 0-2 staged values; 5 CTRL.
  - 6 STATUS = {16'b0, count[7:0], 3'b0, err, ovf, busy, full, empty}.
  - 7 DONE_CNT: 32-bit completed transfers, wraps 0xFFFF_FFFF -> 0.
  - 3 and 4 read 0.
- Push rules:
  - PUSH with LEN_STAGE==0: dropped, err set.
  - PUSH when full and no pop in the same cycle: dropped, ovf set.
  - PUSH when full in the same cycle as a pop: accepted, count unchanged.
  - Staging registers keep their values after a push, so repeated PUSH re-queues the same triplet.
- FSM states: IDLE, LOAD, RUN, DRAIN, GAP.
  - IDLE: run_en=1 and !empty -> LOAD.
  - LOAD: pop head into dma_src/dst/len; dma_en<=1 -> RUN.
  - RUN: dma_en held 1 until dma_done=1, then dma_en<=0 -> DRAIN. DONE_CNT increments by 1. irq is set if irq_en=1.
  - DRAIN: wait for dma_done=0 -> GAP.
  - GAP: one idle cycle so the engine can re-latch its inputs -> IDLE.
- busy = (state != IDLE).
- Clearing run_en mid-transfer lets the current descriptor finish. No further LOAD happens until run_en=1 again. The queue is preserved.
- irq set and CLR bit0 in the same cycle: set wins. Same rule for ovf and err.
- count width is log2(DEPTH)+1, zero-extended into STATUS. Pointers wrap modulo DEPTH.

## Timing
- Reset values: dma_en=0, dma_src=dma_dst=dma_len=0, irq=0, state=IDLE. Also cleared: FIFO empty, staging regs, CTRL, DONE_CNT, ovf, err.
- Register writes take effect on the next clock edge. cfg_rdata reflects current register state combinationally.
- PUSH at edge t: empty=0 visible from t+1. If run_en=1 and IDLE, LOAD at t+1 and dma_en=1 at t+2.
- Minimum spacing between descriptors is 4 cycles of dma_en=0: from dma_done sampled high to the next dma_en rise, given dma_done drops on the cycle after dma_en falls.
- dma_done high at edge t in RUN gives dma_en=0, DONE_CNT+1 and irq=1 at t+1.
- dma_done asserted outside RUN is ignored.
- An asynchronous reset mid-transfer drops dma_en immediately and flushes the queue. Software must also reset or idle the engine.

## Test plan
- Single descriptor:
  - Stimulus: SRC=0x1000, DST=0x2000, LEN=16, PUSH; CTRL=3; engine model pulses dma_done 20 cycles after dma_en.
  - Required: dma_en rises 2 cycles after the CTRL write; outputs hold 0x1000/0x2000/16; DONE_CNT=1; irq=1; CLR bit0 clears irq.
- Back-to-back queue:
  - Stimulus: push 4 distinct descriptors with DEPTH=4, then CTRL=1.
  - Required: issued in FIFO order; 4 completions; DONE_CNT=4; irq stays 0 because irq_en=0; empty=1 at end.
- Overflow and error:
  - Stimulus: with run_en=0, push 5 descriptors, then push one with LEN=0.
  - Required: count=4; ovf=1; err=1; the fifth and zero-length descriptors are never issued; CLR=6 clears both.
- Full push with simultaneous pop:
  - Stimulus: fill the FIFO, set run_en, PUSH on the LOAD cycle.
  - Required: count stays 4, ovf=0, the new descriptor is issued last.
- Disable and reset mid-run:
  - Stimulus: clear run_en during RUN.
  - Required: the current transfer completes and the next stays queued until run_en=1.
  - Stimulus: assert rst during RUN.
  - Required: dma_en=0 immediately, empty=1, DONE_CNT=0.
